// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control path:
// state encoding, opcodes, ALU operation and operand-mux selects.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      LDWB    = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ILLEGAL = 4'd9
   } state_t;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_mem_state(input state_t s);
      logic r;
      case (s)
         FETCH, MEMRD, MEMWR: r = 1'b1;
         default:             r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I-subset datapath (add/sub/and/or/lw/sw/beq),
// with a memory-ready handshake and a wrapping retired-instruction counter.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                pc_src,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic                illegal_instr,
   output logic [3:0]          state_dbg,
   output logic [RETIRE_W-1:0] retired
);

   state_t                state_r;
   state_t                next_state_s;
   logic                  retire_s;
   logic                  is_store_r;
   logic                  mem_req_r;
   logic [RETIRE_W-1:0]   retired_r;

   // The branch decision is taken in the datapath via pc_write_cond; zero is not needed here.
   logic                  zero_unused_s;
   assign zero_unused_s = zero;

   // State register, lw/sw selector latched in DECODE, request flag and retire counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= FETCH;
         is_store_r <= 1'b0;
         mem_req_r  <= 1'b1;
         retired_r  <= {RETIRE_W{1'b0}};
      end else begin
         state_r   <= next_state_s;
         mem_req_r <= is_mem_state(next_state_s);
         if (state_r == DECODE) begin
            is_store_r <= opcode[5];
         end else begin
            is_store_r <= is_store_r;
         end
         if (retire_s) begin
            retired_r <= retired_r + RETIRE_W'(1);
         end else begin
            retired_r <= retired_r;
         end
      end
   end

   // Next-state selection and retire strobe.
   always_comb begin
      next_state_s = state_r;
      retire_s     = 1'b0;
      case (state_r)
         FETCH: begin
            if (mem_ready) begin
               next_state_s = DECODE;
            end else begin
               next_state_s = FETCH;
            end
         end
         DECODE: begin
            case (opcode)
               OPC_R:          next_state_s = EXEC;
               OPC_LW, OPC_SW: next_state_s = MEMADR;
               OPC_BEQ:        next_state_s = BRANCH;
               default:        next_state_s = ILLEGAL;
            endcase
         end
         MEMADR: begin
            if (is_store_r) begin
               next_state_s = MEMWR;
            end else begin
               next_state_s = MEMRD;
            end
         end
         MEMRD: begin
            if (mem_ready) begin
               next_state_s = LDWB;
            end else begin
               next_state_s = MEMRD;
            end
         end
         LDWB: begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
         end
         MEMWR: begin
            if (mem_ready) begin
               next_state_s = FETCH;
               retire_s     = 1'b1;
            end else begin
               next_state_s = MEMWR;
            end
         end
         EXEC:    next_state_s = ALUWB;
         ALUWB: begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
         end
         BRANCH: begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
         end
         ILLEGAL: next_state_s = FETCH;
         default: next_state_s = FETCH;
      endcase
   end

   // Moore output decode; FETCH also strobes IR/PC loads on the completing cycle.
   always_comb begin
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      illegal_instr = 1'b0;
      case (state_r)
         FETCH: begin
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = SRCB_IMM;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         LDWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            iord   = 1'b1;
            mem_we = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_RTYPE;
         end
         ALUWB: begin
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 1'b1;
         end
         ILLEGAL: begin
            illegal_instr = 1'b1;
         end
         default: begin
            illegal_instr = 1'b0;
         end
      endcase
   end

   assign mem_req   = mem_req_r;
   assign state_dbg = state_r;
   assign retired   = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction sequence followed by
// randomized instructions, each expanded into an expected per-cycle trace.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
   logic        reg_write, mem_to_reg, alu_src_a, illegal_instr;
   logic [1:0]  alu_src_b, alu_op;
   logic [3:0]  state_dbg;
   logic [31:0] retired;

   logic        s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_write_cond, s_pc_src;
   logic        s_reg_write, s_mem_to_reg, s_alu_src_a, s_illegal_instr;
   logic [1:0]  s_alu_src_b, s_alu_op;
   logic [3:0]  s_state_dbg;
   logic [2:0]  s_retired;

   always #5 clk = ~clk;

   multicycle_control #(.RETIRE_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr),
      .state_dbg(state_dbg), .retired(retired)
   );

   // Narrow counter instance: exercises the all-ones to zero wrap within a short run.
   multicycle_control #(.RETIRE_W(3)) dut_small (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord), .ir_write(s_ir_write),
      .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .pc_src(s_pc_src),
      .reg_write(s_reg_write), .mem_to_reg(s_mem_to_reg), .alu_src_a(s_alu_src_a),
      .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .illegal_instr(s_illegal_instr),
      .state_dbg(s_state_dbg), .retired(s_retired)
   );

   logic [14:0] outv, s_outv;
   assign outv   = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_instr};
   assign s_outv = {s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_write_cond, s_pc_src,
                    s_reg_write, s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_alu_op, s_illegal_instr};

   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

   typedef struct {
      int st;
      bit mr;
      bit ret;
   } cyc_t;

   cyc_t        plan[$];
   logic [14:0] out_tab [10];
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned model_cnt = 0;
   string       tag = "";

   // Fields: req we iord irw pcw pwc pcs rw m2r a b op ill (irw/pcw follow mem_ready in FETCH)
   initial begin
      out_tab[0] = 15'b1_0_0_0_0_0_0_0_0_0_01_00_0;
      out_tab[1] = 15'b0_0_0_0_0_0_0_0_0_0_10_00_0;
      out_tab[2] = 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
      out_tab[3] = 15'b1_0_1_0_0_0_0_0_0_0_00_00_0;
      out_tab[4] = 15'b0_0_0_0_0_0_0_1_1_0_00_00_0;
      out_tab[5] = 15'b1_1_1_0_0_0_0_0_0_0_00_00_0;
      out_tab[6] = 15'b0_0_0_0_0_0_0_0_0_1_00_10_0;
      out_tab[7] = 15'b0_0_0_0_0_0_0_1_0_0_00_00_0;
      out_tab[8] = 15'b0_0_0_0_0_1_1_0_0_1_00_01_0;
      out_tab[9] = 15'b0_0_0_0_0_0_0_0_0_0_00_00_1;
   end

   function automatic logic [14:0] expect_out(input int st, input bit mr);
      logic [14:0] v;
      v = out_tab[st];
      if (st == 0) begin
         v[11] = mr;
         v[10] = mr;
      end
      return v;
   endfunction

   function automatic logic [6:0] rand_illegal();
      logic [6:0] o;
      do o = 7'($urandom);
      while (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011);
      return o;
   endfunction

   task automatic add(input int st, input bit mr, input bit ret);
      cyc_t c;
      c.st = st; c.mr = mr; c.ret = ret;
      plan.push_back(c);
   endtask

   // Expected trace of one instruction: fetch waits, decode, then the class-specific phases.
   task automatic build(input int kind, input int fw, input int mw);
      plan.delete();
      repeat (fw) add(0, 1'b0, 1'b0);
      add(0, 1'b1, 1'b0);
      add(1, 1'($urandom), 1'b0);
      case (kind)
         K_R: begin
            add(6, 1'($urandom), 1'b0);
            add(7, 1'($urandom), 1'b1);
         end
         K_LW: begin
            add(2, 1'($urandom), 1'b0);
            repeat (mw) add(3, 1'b0, 1'b0);
            add(3, 1'b1, 1'b0);
            add(4, 1'($urandom), 1'b1);
         end
         K_SW: begin
            add(2, 1'($urandom), 1'b0);
            repeat (mw) add(5, 1'b0, 1'b0);
            add(5, 1'b1, 1'b1);
         end
         K_BEQ:   add(8, 1'($urandom), 1'b1);
         default: add(9, 1'($urandom), 1'b0);
      endcase
   endtask

   task automatic check(input int st, input bit mr);
      logic [14:0] e;
      e = expect_out(st, mr);
      vectors++;
      assert (state_dbg === 4'(st)) else begin
         miscompares++;
         $error("FAIL %s state_dbg observed=%0d expected=%0d", tag, state_dbg, st);
      end
      vectors++;
      assert (outv === e) else begin
         miscompares++;
         $error("FAIL %s outputs(st=%0d) observed=%b expected=%b", tag, st, outv, e);
      end
      vectors++;
      assert (retired === 32'(model_cnt)) else begin
         miscompares++;
         $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, model_cnt);
      end
      vectors++;
      assert ({s_state_dbg, s_outv, s_retired} === {4'(st), e, 3'(model_cnt % 8)}) else begin
         miscompares++;
         $error("FAIL %s narrow st/out/retired observed=%0d/%b/%0d expected=%0d/%b/%0d", tag,
                s_state_dbg, s_outv, s_retired, st, e, model_cnt % 8);
      end
   endtask

   // Plays the planned trace; opcode is only meaningful in DECODE, so it is scrambled elsewhere.
   task automatic run_plan(input logic [6:0] opc, input bit zv, input int abort_idx);
      foreach (plan[i]) begin
         @(negedge clk);
         rst_n     = (i == abort_idx) ? 1'b0 : 1'b1;
         mem_ready = plan[i].mr;
         opcode    = (plan[i].st == 1) ? opc : 7'($urandom);
         zero      = (plan[i].st == 8) ? zv : 1'($urandom);
         #1;
         check(plan[i].st, plan[i].mr);
         if (i == abort_idx) begin
            model_cnt = 0;
            return;
         end
         if (plan[i].ret) model_cnt++;
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst_n = 1'b0; opcode = 7'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b0; opcode = 7'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      model_cnt = 0;
      #1;
      check(0, mem_ready);
   endtask

   function automatic logic [6:0] opc_of(input int kind);
      case (kind)
         K_R:     return 7'b0110011;
         K_LW:    return 7'b0000011;
         K_SW:    return 7'b0100011;
         K_BEQ:   return 7'b1100011;
         default: return rand_illegal();
      endcase
   endfunction

   initial begin
      tag = "reset";   do_reset(2);
      tag = "rtype";   build(K_R, 0, 0);   run_plan(7'b0110011, 1'b0, -1);
      tag = "lw_wait"; build(K_LW, 0, 2);  run_plan(7'b0000011, 1'b0, -1);
      tag = "sw";      build(K_SW, 0, 0);  run_plan(7'b0100011, 1'b0, -1);
      tag = "beq_z1";  build(K_BEQ, 0, 0); run_plan(7'b1100011, 1'b1, -1);
      tag = "beq_z0";  build(K_BEQ, 1, 0); run_plan(7'b1100011, 1'b0, -1);
      tag = "illegal"; build(K_ILL, 0, 0); run_plan(7'b1111111, 1'b0, -1);
      tag = "rtype2";  build(K_R, 2, 0);   run_plan(7'b0110011, 1'b0, -1);
      tag = "rst_mrd"; build(K_LW, 0, 2);  run_plan(7'b0000011, 1'b0, 3);
      do_reset(0);
      tag = "random";
      for (int n = 0; n < 200; n++) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         build(kind, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         run_plan(opc_of(kind), 1'($urandom), -1);
      end
      tag = "final_reset"; do_reset(1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
